// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// MIPS-style D stage. It holds the 32x32 register file, forwards the rs/rt
// operands, resolves branches and jumps, and builds the D->E pipeline register.
//
// Ports
//   Clk, Reset            single clock; synchronous active-high reset
//   IRD, PC4D, ExcCodeD   instruction in D, its PC+4, its fetch exception code
//   StallD, FlushE        hazard stall (D holds, bubble to E); flush (bubble to E)
//   RegWriteW, A3W, WDW   W-stage register write port
//   FwdRS_D, FwdRT_D      operand selects: 0 regfile, 1 FwdDataE, 2 FwdDataM, 3 zero
//   FwdDataE, FwdDataM    forwarded data from the E and M stages
//   NPC, NPC_Sel          redirect target and fetch select (0 seq, 1 NPC, 2 rs)
//   Branch                IRD is beq or bne
//   MF_RS_D_OUT           forwarded rs value (jr/jalr target)
//   IRE..ExcCodeE         E pipeline register outputs
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module decode_stage (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] IRD,
   input  logic [31:0] PC4D,
   input  logic [6:2]  ExcCodeD,
   input  logic        StallD,
   input  logic        FlushE,
   input  logic        RegWriteW,
   input  logic [4:0]  A3W,
   input  logic [31:0] WDW,
   input  logic [1:0]  FwdRS_D,
   input  logic [1:0]  FwdRT_D,
   input  logic [31:0] FwdDataE,
   input  logic [31:0] FwdDataM,
   output logic [31:0] NPC,
   output logic [1:0]  NPC_Sel,
   output logic        Branch,
   output logic [31:0] MF_RS_D_OUT,
   output logic [31:0] IRE,
   output logic [31:0] PC4E,
   output logic [31:0] RS_E,
   output logic [31:0] RT_E,
   output logic [31:0] EXT_E,
   output logic [6:2]  ExcCodeE
);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;

   localparam logic [1:0] SEL_SEQ = 2'd0;
   localparam logic [1:0] SEL_NPC = 2'd1;
   localparam logic [1:0] SEL_RS  = 2'd2;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rf_q [32];
   logic [31:0] rs_rf;
   logic [31:0] rt_rf;
   logic [31:0] rs_fwd;
   logic [31:0] rt_fwd;
   logic [31:0] ext;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic        is_beq, is_bne, is_j, is_jr;

   logic [31:0] ire_q, ire_d;
   logic [31:0] pc4e_q, pc4e_d;
   logic [31:0] rse_q, rse_d;
   logic [31:0] rte_q, rte_d;
   logic [31:0] exte_q, exte_d;
   logic [6:2]  exce_q, exce_d;

   assign opcode  = IRD[31:26];
   assign funct   = IRD[5:0];
   assign rs_addr = IRD[25:21];
   assign rt_addr = IRD[20:16];

   // Register file. $0 is never written, so it stays at its reset value of 0.
   // NOTE: this array is cleared on reset because the behaviour requires every
   // register to read 0 afterwards; a plain RAM would normally not be reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (RegWriteW && (A3W != 5'd0)) begin
         // NOTE: non-blocking so every register samples pre-edge values.
         rf_q[A3W] <= WDW;
      end
   end

   // Same-cycle W bypass: a write landing this edge is visible to D now.
   always_comb begin
      // NOTE: defaults first so no path through the block infers a latch.
      rs_rf = rf_q[rs_addr];
      rt_rf = rf_q[rt_addr];
      if (RegWriteW && (A3W != 5'd0) && (A3W == rs_addr)) rs_rf = WDW;
      if (RegWriteW && (A3W != 5'd0) && (A3W == rt_addr)) rt_rf = WDW;
      if (rs_addr == 5'd0) rs_rf = '0;
      if (rt_addr == 5'd0) rt_rf = '0;
   end

   always_comb begin
      unique case (FwdRS_D)
         2'd0:    rs_fwd = rs_rf;
         2'd1:    rs_fwd = FwdDataE;
         2'd2:    rs_fwd = FwdDataM;
         default: rs_fwd = '0;
      endcase
      unique case (FwdRT_D)
         2'd0:    rt_fwd = rt_rf;
         2'd1:    rt_fwd = FwdDataE;
         2'd2:    rt_fwd = FwdDataM;
         default: rt_fwd = '0;
      endcase
   end

   assign MF_RS_D_OUT = rs_fwd;

   // Instruction decode and next-PC selection.
   assign is_beq = (opcode == OP_BEQ);
   assign is_bne = (opcode == OP_BNE);
   assign is_j   = (opcode == OP_J) || (opcode == OP_JAL);
   assign is_jr  = (opcode == OP_SPECIAL) && ((funct == FN_JR) || (funct == FN_JALR));
   assign Branch = is_beq || is_bne;

   assign br_target = PC4D + {{14{IRD[15]}}, IRD[15:0], 2'b00};
   assign j_target  = {PC4D[31:28], IRD[25:0], 2'b00};

   always_comb begin
      NPC     = PC4D + 32'd4;
      NPC_Sel = SEL_SEQ;
      if (is_j) begin
         NPC     = j_target;
         NPC_Sel = SEL_NPC;
      end else if ((is_beq && (rs_fwd == rt_fwd)) || (is_bne && (rs_fwd != rt_fwd))) begin
         NPC     = br_target;
         NPC_Sel = SEL_NPC;
      end else if (is_jr) begin
         NPC_Sel = SEL_RS;
      end
      // Operands are not yet valid during a stall, so never redirect then.
      if (StallD) NPC_Sel = SEL_SEQ;
   end

   // Immediate extension.
   always_comb begin
      unique case (opcode)
         OP_ANDI, OP_ORI, OP_XORI: ext = {16'h0000, IRD[15:0]};
         OP_LUI:                   ext = {IRD[15:0], 16'h0000};
         default:                  ext = {{16{IRD[15]}}, IRD[15:0]};
      endcase
   end

   // E pipeline register: a stall or flush both insert an all-zero bubble.
   always_comb begin
      if (FlushE || StallD) begin
         ire_d  = '0;
         pc4e_d = '0;
         rse_d  = '0;
         rte_d  = '0;
         exte_d = '0;
         exce_d = '0;
      end else begin
         ire_d  = IRD;
         pc4e_d = PC4D;
         rse_d  = rs_fwd;
         rte_d  = rt_fwd;
         exte_d = ext;
         exce_d = ExcCodeD;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ire_q  <= '0;
         pc4e_q <= '0;
         rse_q  <= '0;
         rte_q  <= '0;
         exte_q <= '0;
         exce_q <= '0;
      end else begin
         ire_q  <= ire_d;
         pc4e_q <= pc4e_d;
         rse_q  <= rse_d;
         rte_q  <= rte_d;
         exte_q <= exte_d;
         exce_q <= exce_d;
      end
   end

   assign IRE      = ire_q;
   assign PC4E     = pc4e_q;
   assign RS_E     = rse_q;
   assign RT_E     = rte_q;
   assign EXT_E    = exte_q;
   assign ExcCodeE = exce_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Directed self-checking bench for decode_stage. Inputs change 1 ns after the
// rising edge; outputs are sampled 1 ns after that (combinational) or 1 ns
// after the following rising edge (E register).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decode_stage;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] IRD, PC4D;
   logic [6:2]  ExcCodeD;
   logic        StallD, FlushE, RegWriteW;
   logic [4:0]  A3W;
   logic [31:0] WDW;
   logic [1:0]  FwdRS_D, FwdRT_D;
   logic [31:0] FwdDataE, FwdDataM;
   logic [31:0] NPC;
   logic [1:0]  NPC_Sel;
   logic        Branch;
   logic [31:0] MF_RS_D_OUT, IRE, PC4E, RS_E, RT_E, EXT_E;
   logic [6:2]  ExcCodeE;

   int checks = 0;
   int errors = 0;

   decode_stage dut (
      .Clk(Clk), .Reset(Reset), .IRD(IRD), .PC4D(PC4D), .ExcCodeD(ExcCodeD),
      .StallD(StallD), .FlushE(FlushE), .RegWriteW(RegWriteW), .A3W(A3W),
      .WDW(WDW), .FwdRS_D(FwdRS_D), .FwdRT_D(FwdRT_D), .FwdDataE(FwdDataE),
      .FwdDataM(FwdDataM), .NPC(NPC), .NPC_Sel(NPC_Sel), .Branch(Branch),
      .MF_RS_D_OUT(MF_RS_D_OUT), .IRE(IRE), .PC4E(PC4E), .RS_E(RS_E),
      .RT_E(RT_E), .EXT_E(EXT_E), .ExcCodeE(ExcCodeE)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      RegWriteW = 1'b1; A3W = a; WDW = d;
      tick();
      RegWriteW = 1'b0; A3W = '0; WDW = '0;
   endtask

   task automatic test_reset();
      // Reset must win over flush, stall and a pending register write.
      Reset = 1'b1; FlushE = 1'b1; StallD = 1'b1;
      RegWriteW = 1'b1; A3W = 5'd3; WDW = 32'd99;
      IRD = 32'h3C01_1234; PC4D = 32'h3004; ExcCodeD = 5'd4;
      tick();
      checks++; if (IRE !== 32'h0) begin errors++; $display("FAIL reset_IRE got %h exp %h", IRE, 32'h0); end
      checks++; if (PC4E !== 32'h0) begin errors++; $display("FAIL reset_PC4E got %h exp %h", PC4E, 32'h0); end
      checks++; if (EXT_E !== 32'h0) begin errors++; $display("FAIL reset_EXT_E got %h exp %h", EXT_E, 32'h0); end
      checks++; if (ExcCodeE !== 5'h0) begin errors++; $display("FAIL reset_ExcCodeE got %h exp %h", ExcCodeE, 5'h0); end
      Reset = 1'b0; FlushE = 1'b0; StallD = 1'b0; RegWriteW = 1'b0; ExcCodeD = '0;
      IRD = 32'h0060_0008; // jr $3
      #1;
      checks++; if (MF_RS_D_OUT !== 32'h0) begin errors++; $display("FAIL reset_reg3 got %h exp %h", MF_RS_D_OUT, 32'h0); end
   endtask

   task automatic test_lui();
      IRD = 32'h3C01_1234; PC4D = 32'h3004;
      tick();
      checks++; if (IRE !== 32'h3C01_1234) begin errors++; $display("FAIL lui_IRE got %h exp %h", IRE, 32'h3C01_1234); end
      checks++; if (PC4E !== 32'h3004) begin errors++; $display("FAIL lui_PC4E got %h exp %h", PC4E, 32'h3004); end
      checks++; if (EXT_E !== 32'h1234_0000) begin errors++; $display("FAIL lui_EXT_E got %h exp %h", EXT_E, 32'h1234_0000); end
   endtask

   task automatic test_branch();
      write_reg(5'd1, 32'd5);
      write_reg(5'd2, 32'd5);
      IRD = 32'h1022_0003; PC4D = 32'h3008; // beq $1,$2,+3
      #1;
      checks++; if (NPC_Sel !== 2'd1) begin errors++; $display("FAIL beq_sel got %0d exp %0d", NPC_Sel, 1); end
      checks++; if (NPC !== 32'h3014) begin errors++; $display("FAIL beq_npc got %h exp %h", NPC, 32'h3014); end
      checks++; if (Branch !== 1'b1) begin errors++; $display("FAIL beq_branch got %b exp %b", Branch, 1'b1); end
      IRD = 32'h1422_0003; // bne, operands equal -> not taken
      #1;
      checks++; if (NPC_Sel !== 2'd0) begin errors++; $display("FAIL bne_sel got %0d exp %0d", NPC_Sel, 0); end
      checks++; if (NPC !== 32'h300C) begin errors++; $display("FAIL bne_npc got %h exp %h", NPC, 32'h300C); end
      checks++; if (Branch !== 1'b1) begin errors++; $display("FAIL bne_branch got %b exp %b", Branch, 1'b1); end
      IRD = 32'h1022_FFFF; // beq backward by one word
      #1;
      checks++; if (NPC !== 32'h3004) begin errors++; $display("FAIL beq_back_npc got %h exp %h", NPC, 32'h3004); end
      FwdRT_D = 2'd1; FwdDataE = 32'd6; IRD = 32'h1422_0003; // bne with forwarded rt=6
      #1;
      checks++; if (NPC_Sel !== 2'd1) begin errors++; $display("FAIL bne_fwd_sel got %0d exp %0d", NPC_Sel, 1); end
      FwdRT_D = 2'd0; FwdDataE = '0;
   endtask

   task automatic test_jr();
      RegWriteW = 1'b1; A3W = 5'd8; WDW = 32'hDEAD_BEEF;
      IRD = 32'h0100_0008; PC4D = 32'h3010; // jr $8
      #1;
      checks++; if (MF_RS_D_OUT !== 32'hDEAD_BEEF) begin errors++; $display("FAIL jr_bypass got %h exp %h", MF_RS_D_OUT, 32'hDEAD_BEEF); end
      checks++; if (NPC_Sel !== 2'd2) begin errors++; $display("FAIL jr_sel got %0d exp %0d", NPC_Sel, 2); end
      checks++; if (Branch !== 1'b0) begin errors++; $display("FAIL jr_branch got %b exp %b", Branch, 1'b0); end
      tick();
      RegWriteW = 1'b0; A3W = '0; WDW = '0;
      IRD = 32'h0100_0009; // jalr $8, now from the register file
      #1;
      checks++; if (MF_RS_D_OUT !== 32'hDEAD_BEEF) begin errors++; $display("FAIL jalr_rf got %h exp %h", MF_RS_D_OUT, 32'hDEAD_BEEF); end
      checks++; if (NPC_Sel !== 2'd2) begin errors++; $display("FAIL jalr_sel got %0d exp %0d", NPC_Sel, 2); end
   endtask

   task automatic test_jump();
      IRD = 32'h0800_0C00; PC4D = 32'h3000_3004; // j 0x0000C00
      #1;
      checks++; if (NPC !== 32'h3000_3000) begin errors++; $display("FAIL j_npc got %h exp %h", NPC, 32'h3000_3000); end
      checks++; if (NPC_Sel !== 2'd1) begin errors++; $display("FAIL j_sel got %0d exp %0d", NPC_Sel, 1); end
      IRD = 32'h0C00_0001; PC4D = 32'hF000_0000; // jal
      #1;
      checks++; if (NPC !== 32'hF000_0004) begin errors++; $display("FAIL jal_npc got %h exp %h", NPC, 32'hF000_0004); end
      RegWriteW = 1'b1; A3W = 5'd0; WDW = 32'h1234_5678;
      IRD = 32'h0000_0008; // jr $0
      #1;
      checks++; if (MF_RS_D_OUT !== 32'h0) begin errors++; $display("FAIL r0_bypass got %h exp %h", MF_RS_D_OUT, 32'h0); end
      tick();
      RegWriteW = 1'b0; WDW = '0;
      #1;
      checks++; if (MF_RS_D_OUT !== 32'h0) begin errors++; $display("FAIL r0_read got %h exp %h", MF_RS_D_OUT, 32'h0); end
   endtask

   task automatic test_exc_fwd();
      ExcCodeD = 5'd4; IRD = 32'h3421_8000; PC4D = 32'h3020; // ori $1,$1,0x8000
      FwdRS_D = 2'd1; FwdDataE = 32'd7; FwdRT_D = 2'd2; FwdDataM = 32'h55;
      tick();
      checks++; if (ExcCodeE !== 5'd4) begin errors++; $display("FAIL exc_code got %h exp %h", ExcCodeE, 5'd4); end
      checks++; if (EXT_E !== 32'h0000_8000) begin errors++; $display("FAIL ori_ext got %h exp %h", EXT_E, 32'h0000_8000); end
      checks++; if (RS_E !== 32'd7) begin errors++; $display("FAIL fwd_rs_e got %h exp %h", RS_E, 32'd7); end
      checks++; if (RT_E !== 32'h55) begin errors++; $display("FAIL fwd_rt_m got %h exp %h", RT_E, 32'h55); end
      // Back-to-back: addi sign-extends, select 3 forces zero.
      ExcCodeD = '0; IRD = 32'h2001_8000; FwdRS_D = 2'd3; FwdRT_D = 2'd0;
      tick();
      checks++; if (EXT_E !== 32'hFFFF_8000) begin errors++; $display("FAIL addi_ext got %h exp %h", EXT_E, 32'hFFFF_8000); end
      checks++; if (RS_E !== 32'h0) begin errors++; $display("FAIL fwd_zero got %h exp %h", RS_E, 32'h0); end
      checks++; if (RT_E !== 32'd5) begin errors++; $display("FAIL rt_rf got %h exp %h", RT_E, 32'd5); end
      checks++; if (ExcCodeE !== 5'd0) begin errors++; $display("FAIL exc_clear got %h exp %h", ExcCodeE, 5'd0); end
      FwdRS_D = 2'd0; FwdDataE = '0; FwdDataM = '0;
   endtask

   task automatic test_stall_flush();
      IRD = 32'h1022_0003; PC4D = 32'h3008; StallD = 1'b1; // beq taken, but stalled
      #1;
      checks++; if (NPC_Sel !== 2'd0) begin errors++; $display("FAIL stall_sel got %0d exp %0d", NPC_Sel, 0); end
      tick();
      checks++; if (IRE !== 32'h0) begin errors++; $display("FAIL stall_IRE got %h exp %h", IRE, 32'h0); end
      checks++; if (PC4E !== 32'h0) begin errors++; $display("FAIL stall_PC4E got %h exp %h", PC4E, 32'h0); end
      StallD = 1'b0;
      tick();
      checks++; if (RS_E !== 32'd5) begin errors++; $display("FAIL resume_RS_E got %h exp %h", RS_E, 32'd5); end
      FlushE = 1'b1; StallD = 1'b1;
      tick();
      checks++; if (IRE !== 32'h0) begin errors++; $display("FAIL flushstall_IRE got %h exp %h", IRE, 32'h0); end
      checks++; if (RS_E !== 32'h0) begin errors++; $display("FAIL flushstall_RS_E got %h exp %h", RS_E, 32'h0); end
      FlushE = 1'b0; StallD = 1'b0;
      tick();
      Reset = 1'b1; FlushE = 1'b1;
      tick();
      checks++; if (IRE !== 32'h0) begin errors++; $display("FAIL rstflush_IRE got %h exp %h", IRE, 32'h0); end
      checks++; if (EXT_E !== 32'h0) begin errors++; $display("FAIL rstflush_EXT_E got %h exp %h", EXT_E, 32'h0); end
      Reset = 1'b0; FlushE = 1'b0;
      tick();
      checks++; if (IRE !== 32'h1022_0003) begin errors++; $display("FAIL postrst_IRE got %h exp %h", IRE, 32'h1022_0003); end
      checks++; if (RS_E !== 32'h0) begin errors++; $display("FAIL postrst_RS_E got %h exp %h", RS_E, 32'h0); end
   endtask

   initial begin
      Reset = 1'b0; IRD = '0; PC4D = '0; ExcCodeD = '0; StallD = 1'b0; FlushE = 1'b0;
      RegWriteW = 1'b0; A3W = '0; WDW = '0; FwdRS_D = '0; FwdRT_D = '0;
      FwdDataE = '0; FwdDataM = '0;
      test_reset();
      test_lui();
      test_branch();
      test_jr();
      test_jump();
      test_exc_fwd();
      test_stall_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
